// File: rtl/sprite_draw_scheduler.sv
// Round-robin scheduler that hands a single VGA plot port to one of four sprite
// requesters and walks that requester's 5x5 mask. Optional macro: SCHED_ERASE_FIRST_EN.
module sprite_draw_scheduler (
   input  logic          clock,
   input  logic          reset,
   input  logic [3:0]    req,
   input  logic [3:0]    erase_in,
   input  logic [31:0]   x_in,
   input  logic [27:0]   y_in,
   input  logic [11:0]   colour_in,
   input  logic [99:0]   shape_in,
   output logic [3:0]    grant,
   output logic [3:0]    done,
   output logic          busy,
   output logic          plot_en,
   output logic [7:0]    x,
   output logic [6:0]    y,
   output logic [2:0]    colour
);

   localparam int unsigned N  = 4;
   localparam int unsigned PW = 2;
   localparam int unsigned XW = 8;
   localparam int unsigned YW = 7;
   localparam int unsigned CW = 3;
   localparam int unsigned SW = 25;
   localparam int unsigned LW = 5;
   localparam int unsigned RW = 3;
   localparam logic [LW-1:0] LAST_LOC = LW'(SW - 1);
   localparam logic [RW-1:0] LAST_COL = RW'(4);

   typedef enum logic [1:0] {IDLE, LATCH, DRAW, DONE} state_e;

   state_e           state_q, state_d;
   logic [PW-1:0]    ptr_q, ptr_d;
   logic [PW-1:0]    gidx_q, gidx_d;
   logic [N-1:0]     grant_q, grant_d;
   logic [N-1:0]     done_q, done_d;
   logic             busy_q, busy_d;
   logic [LW-1:0]    loc_q, loc_d;
   logic [RW-1:0]    row_q, row_d;
   logic [RW-1:0]    col_q, col_d;
   logic [XW-1:0]    xbase_q, xbase_d;
   logic [YW-1:0]    ybase_q, ybase_d;
   logic [CW-1:0]    col_reg_q, col_reg_d;
   logic [SW-1:0]    shape_q, shape_d;
   logic             erase_q, erase_d;
   logic             plot_en_q, plot_en_d;
   logic [XW-1:0]    x_q, x_d;
   logic [YW-1:0]    y_q, y_d;
   logic [CW-1:0]    colour_q, colour_d;

   logic [XW-1:0]    x_lane [N];
   logic [YW-1:0]    y_lane [N];
   logic [CW-1:0]    c_lane [N];
   logic [SW-1:0]    s_lane [N];

   logic [N-1:0]     cand;
   logic             win_found;
   logic [PW-1:0]    win_idx;

   // Split the flat buses into per-requester lanes.
   for (genvar i = 0; i < N; i++) begin : g_lane
      assign x_lane[i] = x_in[i*XW +: XW];
      assign y_lane[i] = y_in[i*YW +: YW];
      assign c_lane[i] = colour_in[i*CW +: CW];
      assign s_lane[i] = shape_in[i*SW +: SW];
   end

   // Round-robin search starting at ptr_q.
   always_comb begin
      cand      = req;
      win_found = 1'b0;
      win_idx   = '0;
`ifdef SCHED_ERASE_FIRST_EN
      if ((req & erase_in) != '0) cand = req & erase_in;
`endif
      for (int k = 0; k < int'(N); k++) begin
         if (!win_found && cand[ptr_q + PW'(k)]) begin
            win_found = 1'b1;
            win_idx   = ptr_q + PW'(k);
         end
      end
   end

   // Next state; pixel outputs are computed one cycle ahead so they leave registers.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      gidx_d    = gidx_q;
      grant_d   = grant_q;
      loc_d     = loc_q;
      row_d     = row_q;
      col_d     = col_q;
      xbase_d   = xbase_q;
      ybase_d   = ybase_q;
      col_reg_d = col_reg_q;
      shape_d   = shape_q;
      erase_d   = erase_q;
      done_d    = '0;
      busy_d    = 1'b0;
      plot_en_d = 1'b0;
      x_d       = '0;
      y_d       = '0;
      colour_d  = '0;

      case (state_q)
         IDLE: begin
            if (win_found) begin
               state_d = LATCH;
               gidx_d  = win_idx;
               grant_d = N'(1) << win_idx;
            end
         end
         LATCH: begin
            state_d   = DRAW;
            xbase_d   = x_lane[gidx_q];
            ybase_d   = y_lane[gidx_q];
            col_reg_d = c_lane[gidx_q];
            shape_d   = s_lane[gidx_q];
            erase_d   = erase_in[gidx_q];
            loc_d     = '0;
            row_d     = '0;
            col_d     = '0;
         end
         DRAW: begin
            if (loc_q == LAST_LOC) begin
               state_d = DONE;
            end else begin
               loc_d = loc_q + LW'(1);
               if (col_q == LAST_COL) begin
                  col_d = '0;
                  row_d = row_q + RW'(1);
               end else begin
                  col_d = col_q + RW'(1);
               end
            end
         end
         DONE: begin
            state_d = IDLE;
            ptr_d   = gidx_q + PW'(1);
            grant_d = '0;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
      if (state_d == DONE) done_d = grant_q;
      if (state_d == DRAW) begin
         plot_en_d = erase_d | shape_d[loc_d];
         x_d       = xbase_d + XW'(col_d);
         y_d       = ybase_d + YW'(row_d);
         colour_d  = erase_d ? '0 : col_reg_d;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         gidx_q    <= '0;
         grant_q   <= '0;
         done_q    <= '0;
         busy_q    <= 1'b0;
         loc_q     <= '0;
         row_q     <= '0;
         col_q     <= '0;
         xbase_q   <= '0;
         ybase_q   <= '0;
         col_reg_q <= '0;
         shape_q   <= '0;
         erase_q   <= 1'b0;
         plot_en_q <= 1'b0;
         x_q       <= '0;
         y_q       <= '0;
         colour_q  <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         gidx_q    <= gidx_d;
         grant_q   <= grant_d;
         done_q    <= done_d;
         busy_q    <= busy_d;
         loc_q     <= loc_d;
         row_q     <= row_d;
         col_q     <= col_d;
         xbase_q   <= xbase_d;
         ybase_q   <= ybase_d;
         col_reg_q <= col_reg_d;
         shape_q   <= shape_d;
         erase_q   <= erase_d;
         plot_en_q <= plot_en_d;
         x_q       <= x_d;
         y_q       <= y_d;
         colour_q  <= colour_d;
      end
   end

   assign grant   = grant_q;
   assign done    = done_q;
   assign busy    = busy_q;
   assign plot_en = plot_en_q;
   assign x       = x_q;
   assign y       = y_q;
   assign colour  = colour_q;

endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// Self-checking bench for sprite_draw_scheduler: table of single-sprite draws
// scored pixel by pixel, plus round-robin, mid-draw reset and erase-priority sequences.
module tb_sprite_draw_scheduler;

   logic          clock;
   logic          reset;
   logic [3:0]    req;
   logic [3:0]    erase_in;
   logic [31:0]   x_in;
   logic [27:0]   y_in;
   logic [11:0]   colour_in;
   logic [99:0]   shape_in;
   logic [3:0]    grant;
   logic [3:0]    done;
   logic          busy;
   logic          plot_en;
   logic [7:0]    x;
   logic [6:0]    y;
   logic [2:0]    colour;

   int n_cmp = 0;
   int n_bad = 0;

   logic [17:0] sb[$];

   typedef struct {
      int          idx;
      logic        erase;
      logic [7:0]  xb;
      logic [6:0]  yb;
      logic [2:0]  col;
      logic [24:0] shape;
      logic        drop;
      logic [3:0]  exp_grant;
      int          exp_plots;
   } vec_t;

   vec_t vecs[5];

   sprite_draw_scheduler dut (
      .clock     (clock),
      .reset     (reset),
      .req       (req),
      .erase_in  (erase_in),
      .x_in      (x_in),
      .y_in      (y_in),
      .colour_in (colour_in),
      .shape_in  (shape_in),
      .grant     (grant),
      .done      (done),
      .busy      (busy),
      .plot_en   (plot_en),
      .x         (x),
      .y         (y),
      .colour    (colour)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // done may only ever pulse the currently granted bit
   always @(negedge clock) begin
      if (done != 4'b0) chk("done_eq_grant", 32'(done), 32'(grant));
   end

   task automatic set_lane(input int i, input logic e, input logic [7:0] xv,
                           input logic [6:0] yv, input logic [2:0] cv, input logic [24:0] sv);
      erase_in[i]          = e;
      x_in[i*8 +: 8]       = xv;
      y_in[i*7 +: 7]       = yv;
      colour_in[i*3 +: 3]  = cv;
      shape_in[i*25 +: 25] = sv;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req   = 4'b0;
      repeat (2) @(negedge clock);
      reset = 1'b0;
   endtask

   // One isolated draw: expected pixels go to the scoreboard, then plots are popped.
   task automatic run_draw(input vec_t v);
      int k, plots, last_plot, c;
      bit got;
      x_in      = $urandom;
      y_in      = 28'($urandom);
      colour_in = 12'($urandom);
      shape_in  = {$urandom, $urandom, $urandom, $urandom};
      erase_in  = 4'($urandom);
      set_lane(v.idx, v.erase, v.xb, v.yb, v.col, v.shape);
      req = 4'b1 << v.idx;
      sb.delete();
      for (int r = 0; r < 5; r++)
         for (int cc = 0; cc < 5; cc++)
            if (v.erase || v.shape[r*5 + cc])
               sb.push_back({8'(v.xb + 8'(cc)), 7'(v.yb + 7'(r)), v.erase ? 3'b000 : v.col});
      k = 0;
      got = 0;
      while (k < 10 && !got) begin
         @(negedge clock);
         k++;
         if (grant != 4'b0) got = 1;
      end
      if (!got) begin
         chk("grant_timeout", 1, 0);
         req = 4'b0;
         return;
      end
      chk("grant_value", 32'(grant), 32'(v.exp_grant));
      chk("grant_latency", 32'(k), 1);
      plots = 0;
      last_plot = 0;
      got = 0;
      c = 0;
      while (c < 40 && !got) begin
         @(negedge clock);
         c++;
         if (plot_en) begin
            plots++;
            last_plot = c;
            if (sb.size() == 0) chk("plot_extra", {14'b0, x, y, colour}, 0);
            else chk("pixel", {14'b0, x, y, colour}, {14'b0, sb.pop_front()});
         end
         if (done != 4'b0) begin
            got = 1;
            chk("done_value", 32'(done), 32'(v.exp_grant));
            chk("done_latency", 32'(c), 26);
         end
         if (c == 2) begin
            x_in      = ~x_in;
            y_in      = ~y_in;
            colour_in = ~colour_in;
            shape_in  = ~shape_in;
            erase_in  = ~erase_in;
            if (v.drop) req = 4'b0;
         end
      end
      if (!got) chk("done_timeout", 1, 0);
      chk("plot_count", 32'(plots), 32'(v.exp_plots));
      chk("plot_window", 32'(last_plot <= 25), 1);
      chk("sb_empty", 32'(sb.size()), 0);
      req = 4'b0;
      @(negedge clock);
   endtask

   // Watch n consecutive draws with req held, checking grant order, plot counts and gaps.
   task automatic watch_order(input int n, input logic [3:0] o0, input logic [3:0] o1,
                              input logic [3:0] o2, input logic [3:0] o3, input logic [3:0] o4);
      logic [3:0] order [5];
      logic [3:0] prev;
      int d, cyc, plots, done_cyc;
      order[0] = o0; order[1] = o1; order[2] = o2; order[3] = o3; order[4] = o4;
      prev = 4'b0;
      d = 0; cyc = 0; plots = 0; done_cyc = 0;
      while (d < n && cyc < 400) begin
         @(negedge clock);
         cyc++;
         if (plot_en) plots++;
         if (grant != 4'b0 && prev == 4'b0) begin
            chk("rr_grant", 32'(grant), 32'(order[d]));
            if (d > 0) chk("rr_regrant_gap", 32'(cyc - done_cyc), 2);
         end
         if (done != 4'b0) begin
            chk("rr_done", 32'(done), 32'(order[d]));
            chk("rr_plots", 32'(plots), 25);
            plots = 0;
            done_cyc = cyc;
            d++;
            if (d == n) req = 4'b0;
         end
         prev = grant;
      end
      if (d < n) chk("rr_timeout", 32'(d), 32'(n));
      req = 4'b0;
      repeat (2) @(negedge clock);
   endtask

   initial begin
      vecs[0] = '{idx:0, erase:1'b0, xb:8'd10,  yb:7'd20,  col:3'b110, shape:25'h1FFFFFF,
                  drop:1'b0, exp_grant:4'b0001, exp_plots:25};
      vecs[1] = '{idx:1, erase:1'b0, xb:8'd77,  yb:7'd33,  col:3'b101, shape:25'h0000001,
                  drop:1'b1, exp_grant:4'b0010, exp_plots:1};
      vecs[2] = '{idx:1, erase:1'b1, xb:8'd77,  yb:7'd33,  col:3'b101, shape:25'h0000001,
                  drop:1'b0, exp_grant:4'b0010, exp_plots:25};
      vecs[3] = '{idx:2, erase:1'b0, xb:8'd254, yb:7'd126, col:3'b011, shape:25'h1FFFFFF,
                  drop:1'b0, exp_grant:4'b0100, exp_plots:25};
      vecs[4] = '{idx:3, erase:1'b0, xb:8'd100, yb:7'd50,  col:3'b010, shape:25'h1555555,
                  drop:1'b1, exp_grant:4'b1000, exp_plots:13};

      reset = 1'b1; req = 4'b0; erase_in = 4'b0;
      x_in = '0; y_in = '0; colour_in = '0; shape_in = '0;
      @(negedge clock);
      @(negedge clock);
      chk("reset_outputs", {10'b0, grant, done, busy, plot_en, x, y, colour}, 0);
      reset = 1'b0;
      @(negedge clock);

      for (int i = 0; i < 5; i++) run_draw(vecs[i]);

      // Four requesters held continuously from reset.
      do_reset();
      for (int i = 0; i < 4; i++) set_lane(i, 1'b0, 8'(i * 40), 7'(i * 20), 3'(i + 1), 25'h1FFFFFF);
      req = 4'b1111;
      watch_order(5, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001);

      // Reset while the pixel at loc 12 is on the port.
      begin
         int plots, k;
         bit seen_done, got;
         do_reset();
         set_lane(0, 1'b0, 8'd5, 7'd5, 3'b111, 25'h1FFFFFF);
         req = 4'b0001;
         plots = 0; k = 0; seen_done = 0;
         while (plots < 13 && k < 60) begin
            @(negedge clock);
            k++;
            if (plot_en) plots++;
         end
         chk("mid_reset_reach_loc12", 32'(plots), 13);
         reset = 1'b1;
         @(negedge clock);
         chk("mid_reset_outputs", {10'b0, grant, done, busy, plot_en, x, y, colour}, 0);
         reset = 1'b0;
         k = 0; got = 0;
         while (k < 10 && !got) begin
            @(negedge clock);
            k++;
            if (done != 4'b0) seen_done = 1;
            if (grant != 4'b0) got = 1;
         end
         chk("mid_reset_no_done", 32'(seen_done), 0);
         chk("mid_reset_regrant", 32'(grant), 32'b0001);
         chk("mid_reset_regrant_latency", 32'(k), 1);
         k = 0; got = 0;
         while (k < 40 && !got) begin
            @(negedge clock);
            k++;
            if (done != 4'b0) got = 1;
         end
         chk("mid_reset_redraw_done", 32'(k), 26);
         req = 4'b0;
         repeat (2) @(negedge clock);
      end

      // Erase-flagged requester against a plain one, pointer at 0.
      do_reset();
      set_lane(0, 1'b0, 8'd1, 7'd1, 3'b001, 25'h1FFFFFF);
      set_lane(1, 1'b1, 8'd2, 7'd2, 3'b010, 25'h1FFFFFF);
      req = 4'b0011;
`ifdef SCHED_ERASE_FIRST_EN
      watch_order(2, 4'b0010, 4'b0001, 4'b0, 4'b0, 4'b0);
`else
      watch_order(2, 4'b0001, 4'b0010, 4'b0, 4'b0, 4'b0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
